fifo_axis_reader: RTL and testbench
===================================

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO read data and of m_axis_tdata.
REQ-002 Parameter PKT_LEN, default 256, beats per packet for TLAST generation; legal range 2..65536.
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
REQ-004 clk  input  1  sole clock; the same clock as the async FIFO read side.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 fifo_rd_en  output  1  read strobe to the async FIFO read port.
REQ-007 fifo_empty  input  1  FIFO empty flag, synchronous to clk.
REQ-008 fifo_dout  input  DATA_WIDTH  FIFO read data, registered; valid one cycle after an accepted read.
REQ-009 m_axis_tdata  output  DATA_WIDTH  AXI-Stream data.
REQ-010 m_axis_tvalid  output  1  AXI-Stream valid.
REQ-011 m_axis_tready  input  1  AXI-Stream ready from the downstream sink.
REQ-012 m_axis_tlast  output  1  AXI-Stream end-of-packet marker.

Function
REQ-013 A read is accepted in a cycle when fifo_rd_en=1 and fifo_empty=0; fifo_rd_en SHALL never be 1 while fifo_empty=1.
REQ-014 A 1-bit inflight register SHALL be set in the cycle after an accepted read; fifo_dout SHALL be captured into the output buffer on that cycle's closing edge.
REQ-015 The output buffer SHALL hold 2 entries (count 0..2) in FIFO order; the head entry drives m_axis_tdata.
REQ-016 fifo_rd_en SHALL equal !fifo_empty && (count + inflight - pop) < 2, where pop = m_axis_tvalid && m_axis_tready.
REQ-017 m_axis_tvalid SHALL equal (count != 0).
REQ-018 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL be held stable.
REQ-019 Latency: if fifo_empty falls in cycle N with the buffer idle, fifo_rd_en=1 in cycle N, m_axis_tvalid=1 in cycle N+2.
REQ-020 With tready held at 1 and the FIFO non-empty, throughput SHALL be 1 beat per cycle with no bubbles.
REQ-021 A simultaneous push and pop SHALL leave count unchanged.
REQ-022 The buffer SHALL never overflow; a push when count=2 and pop=0 is a design error, flagged by an assertion.
REQ-023 The beat counter SHALL be $clog2(PKT_LEN) bits wide, increment on each pop, and wrap from PKT_LEN-1 to 0.

Reset
REQ-024 On rst: fifo_rd_en=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, count=0, inflight=0, beat counter=0.
REQ-025 When rst asserts mid-stream, buffered and inflight data SHALL be discarded; the first beat after release SHALL start a new packet.
REQ-026 fifo_rd_en SHALL remain 0 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro FIFO_AXIS_TLAST_EN defined: m_axis_tlast=1 exactly when the head beat is beat PKT_LEN-1 of a packet (beat counter == PKT_LEN-1).
REQ-028 Macro FIFO_AXIS_TLAST_EN undefined: m_axis_tlast is tied to 0, and the beat counter and PKT_LEN are unused and removed.

Structure
REQ-029 Shared package fifo_axis_pkg SHALL hold the DATA_WIDTH and PKT_LEN defaults and the buffer depth constant (2).
REQ-030 The 2-entry buffer SHALL be a sub-module, axis_skid_buf (push, pop, data in, head data, count).

Verification
REQ-031 Reset release with FIFO pre-loaded with 0x11,0x22,0x33 and tready=1 -> tvalid rises 2 cycles after the first fifo_rd_en; tdata sequence 0x11,0x22,0x33 on consecutive cycles.
REQ-032 tready=0 for 10 cycles while streaming -> exactly 2 extra reads issued, then fifo_rd_en=0; tdata held; on tready=1, no beat is lost or duplicated.
REQ-033 Random tready (50%) over 1000 beats with random fifo_empty -> output sequence equals the FIFO input sequence; fifo_rd_en never 1 while empty.
REQ-034 FIFO_AXIS_TLAST_EN defined, PKT_LEN=4, 12 beats -> tlast=1 on beats 3, 7 and 11 only; undefined -> tlast always 0.
REQ-035 rst pulsed while count=2 and inflight=1 -> tvalid=0 immediately (asynchronous); after release, the first beat accepted carries beat counter 0.

Source files
------------

// File: rtl/fifo_axis_pkg.sv
// Shared constants and types for the FIFO-to-AXI-Stream reader and its 2-entry output buffer.
package fifo_axis_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int PKT_LEN_DEF    = 256;
  localparam int BUF_DEPTH      = 2;
  localparam int CNT_W          = $clog2(BUF_DEPTH + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  // One extra bit so buffered + inflight entries can be summed without wrapping.
  typedef logic [CNT_W:0]   occ_t;

endpackage

// File: rtl/fifo_axis_reader_if.sv
// FIFO read port plus AXI-Stream master bundle; master is the reader, slave is the FIFO/sink side.
interface fifo_axis_reader_if
  import fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_dout,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_dout,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast
  );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry in-order output buffer; entry 0 is always the head presented downstream.
module axis_skid_buf
  import fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output cnt_t                  count
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  cnt_t                  count_q;

  // NOTE: the storage is reset as well because the head drives tdata, which must read 0 in reset.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          mem_q[count_q[0]] <= din;
          count_q           <= count_q + cnt_t'(1);
        end
        2'b01: begin
          mem_q[0] <= mem_q[1];
          count_q  <= count_q - cnt_t'(1);
        end
        2'b11: begin
          // Head leaves while a new beat arrives; count is unchanged.
          if (count_q == cnt_t'(BUF_DEPTH)) begin
            mem_q[0] <= mem_q[1];
            mem_q[1] <= din;
          end else begin
            mem_q[0] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = mem_q[0];
  assign count = count_q;

  ap_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == cnt_t'(BUF_DEPTH))));

  ap_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count_q == '0)));

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains an async FIFO read port (registered dout) into an AXI-Stream master without bubbles.
// Define FIFO_AXIS_TLAST_EN to generate TLAST every PKT_LEN beats; otherwise TLAST is tied low.
module fifo_axis_reader
  import fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef FIFO_AXIS_TLAST_EN
  , parameter int PKT_LEN  = PKT_LEN_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_axis_reader_if.master      bus
);

  logic rst_done_q;
  logic inflight_q;
  logic pop;
  cnt_t count;
  occ_t occ;

  assign pop = bus.m_axis_tvalid && bus.m_axis_tready;

  // rst_done_q keeps reads off for the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done_q <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      inflight_q <= bus.fifo_rd_en;
    end
  end

  // NOTE: occ is assigned on every path, so this block cannot infer a latch.
  always_comb begin
    occ = {1'b0, count} + occ_t'(inflight_q) - occ_t'(pop);
  end

  // Only read when the beat still has a guaranteed slot once it lands.
  assign bus.fifo_rd_en    = rst_done_q && !bus.fifo_empty && (occ < occ_t'(BUF_DEPTH));
  assign bus.m_axis_tvalid = (count != '0);

  axis_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   (bus.fifo_dout),
    .head  (bus.m_axis_tdata),
    .count (count)
  );

`ifdef FIFO_AXIS_TLAST_EN
  localparam int BEAT_W = $clog2(PKT_LEN);

  logic [BEAT_W-1:0] beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
    end else if (pop) begin
      beat_q <= (beat_q == BEAT_W'(PKT_LEN - 1)) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  assign bus.m_axis_tlast = bus.m_axis_tvalid && (beat_q == BEAT_W'(PKT_LEN - 1));
`else
  assign bus.m_axis_tlast = 1'b0;
`endif

  ap_rd_not_empty: assert property (@(posedge clk) disable iff (rst)
    !(bus.fifo_rd_en && bus.fifo_empty));

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench for fifo_axis_reader: behavioural FIFO source, beat scoreboard, timing checks.
// Build with FIFO_AXIS_TLAST_EN defined to exercise TLAST at PKT_LEN=4.
module tb_fifo_axis_reader;
  import fifo_axis_pkg::*;

  localparam int DW = 32;
`ifdef FIFO_AXIS_TLAST_EN
  localparam int PKT_LEN = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_axis_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_axis_reader #(
    .DATA_WIDTH (DW)
`ifdef FIFO_AXIS_TLAST_EN
    , .PKT_LEN  (PKT_LEN)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // FIFO source model: registered dout, empty recomputed every edge.
  logic [DW-1:0] src_mem [2048];
  logic [DW-1:0] log_mem [2048];
  int            src_wr   = 0;
  int            src_rd   = 0;
  int            rd_total = 0;
  logic          starve   = 1'b0;

  always @(posedge clk) begin
    if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_dout    <= src_mem[src_rd];
      log_mem[rd_total] = src_mem[src_rd];
      src_rd++;
      rd_total++;
    end
    bus.fifo_empty <= (src_wr == src_rd) || starve;
  end

  task automatic load(input logic [DW-1:0] d);
    src_mem[src_wr] = d;
    src_wr++;
  endtask

  // Scoreboard: every accepted beat must be the next word read from the FIFO.
  int            out_idx  = 0;
  int            beat_idx = 0;
  int            viol     = 0;
  logic [DW-1:0] exp_d;
  logic          exp_last;

  always @(negedge clk) begin
    if (rst) begin
      out_idx  = rd_total;
      beat_idx = 0;
    end else begin
      if (bus.fifo_rd_en && bus.fifo_empty) viol++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        exp_d = (out_idx < rd_total) ? log_mem[out_idx] : 'x;
        check("beat_tdata", bus.m_axis_tdata, exp_d);
`ifdef FIFO_AXIS_TLAST_EN
        exp_last = (beat_idx == PKT_LEN - 1);
        beat_idx = (beat_idx == PKT_LEN - 1) ? 0 : beat_idx + 1;
`else
        exp_last = 1'b0;
        beat_idx++;
`endif
        check("beat_tlast", bus.m_axis_tlast, exp_last);
        out_idx++;
      end
    end
  end

  task automatic wait_drain(input int exp_total);
    int cyc = 0;
    while ((out_idx != exp_total) && (cyc < 2000)) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("drain_beats", out_idx, exp_total);
    check("drain_reads", rd_total, exp_total);
    check("drain_tvalid", bus.m_axis_tvalid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold_err;
    int cyc;
    bus.m_axis_tready = 1'b0;
    load(32'h11); load(32'h22); load(32'h33);

    // Reset values with the FIFO already holding data.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en",  bus.fifo_rd_en,    0);
    check("rst_tvalid", bus.m_axis_tvalid, 0);
    check("rst_tdata",  bus.m_axis_tdata,  0);
    check("rst_tlast",  bus.m_axis_tlast,  0);

    // Release: idle cycle, read in N, tvalid in N+2, then three back-to-back beats.
    @(posedge clk); #1;
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    @(negedge clk); check("rd_en_after_release", bus.fifo_rd_en, 0);
    @(negedge clk); check("rd_en_cycle_n", bus.fifo_rd_en, 1);
                    check("tvalid_cycle_n", bus.m_axis_tvalid, 0);
    @(negedge clk); check("tvalid_cycle_n1", bus.m_axis_tvalid, 0);
    @(negedge clk); check("tvalid_cycle_n2", bus.m_axis_tvalid, 1);
                    check("tdata_beat0", bus.m_axis_tdata, 32'h11);
    @(negedge clk); check("tdata_beat1", bus.m_axis_tdata, 32'h22);
    @(negedge clk); check("tdata_beat2", bus.m_axis_tdata, 32'h33);
    @(negedge clk); check("tvalid_after_burst", bus.m_axis_tvalid, 0);

    // Back-pressure for 10 cycles mid-stream.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) load(32'h100 + i);
    repeat (6) @(posedge clk);
    #1;
    bus.m_axis_tready = 1'b0;
    hold_err = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.m_axis_tdata !== log_mem[out_idx]) hold_err++;
    end
    check("stall_hold", hold_err, 0);
    check("stall_outstanding", rd_total - out_idx, 2);
    check("stall_rd_en", bus.fifo_rd_en, 0);
    check("stall_tvalid", bus.m_axis_tvalid, 1);
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b1;
    wait_drain(19);

    // Asynchronous reset with a full buffer; the two buffered words are dropped.
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) load(32'h200 + i);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_tvalid", bus.m_axis_tvalid, 0);
    check("async_rst_rd_en",  bus.fifo_rd_en,    0);
    check("async_rst_tdata",  bus.m_axis_tdata,  0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    cyc = 0;
    while (!bus.m_axis_tvalid && (cyc < 20)) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("first_after_rst", bus.m_axis_tdata, 32'h202);
    wait_drain(27);

    // Random back-pressure and random FIFO starvation over 1000 beats.
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) load(DW'($urandom));
    cyc = 0;
    while ((out_idx != 1027) && (cyc < 20000)) begin
      @(posedge clk); #1;
      bus.m_axis_tready = 1'($urandom_range(0, 1));
      starve = ($urandom_range(0, 3) == 0);
      cyc++;
    end
    bus.m_axis_tready = 1'b1;
    starve = 1'b0;
    wait_drain(1027);
    check("rd_en_while_empty", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
